// File: rtl/cpu7_exu_ecl_ldscb.sv
// ----------------------------------------------------------------------------
// cpu7_exu_ecl_ldscb
//
// Long-latency writeback scoreboard and E-stage stall controller.
//
// Loads and divides write their result to the register file several cycles
// after they leave M. Their values never appear on the M/W bypass legs. This
// block records the destination register of every such op from allocation
// (M stage) until completion (RF write in W). It holds the E-stage instruction
// while any of its sources (RAW) or its destination (WAW) matches a pending
// destination. The hold is released only in the cycle after the RF write, so
// the consumer reads the value through the RF leg of the rs mux.
//
// Ports
//   clk        core clock, all state on the rising edge
//   resetn     asynchronous active-low reset
//   alloc_vld  M stage issues a long-latency op writing alloc_rd
//   alloc_rd   destination register of the allocating op
//   alloc_rdy  a free entry exists (combinational from state)
//   alloc_tag  entry taken by an allocation this cycle
//   cmpl_vld   long-latency result written to the RF this cycle
//   cmpl_tag   entry being completed
//   ex_vld     valid instruction in E
//   rs1_e      E-stage source 1
//   rs2_e      E-stage source 2
//   rd_e       E-stage destination
//   wen_e      E-stage instruction writes rd_e
//   stall_e    hold E and upstream stages (combinational)
//   pend_cnt   number of valid entries (registered)
//   cmpl_err   one-cycle registered pulse on a protocol violation
//
// Handshake: an allocation is accepted on a cycle where alloc_vld and
// alloc_rdy are both high. alloc_rdy depends only on registered state, never
// on alloc_vld. alloc_vld while alloc_rdy is low is a protocol error: it is
// dropped and flagged on cmpl_err. Completion has no ready signal. It must
// name a valid entry, or it is dropped and flagged the same way.
// ----------------------------------------------------------------------------
module cpu7_exu_ecl_ldscb #(
    parameter int NUM_ENT = 4,
    parameter int TAG_W   = 2,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             alloc_vld,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_rdy,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cmpl_vld,
    input  logic [TAG_W-1:0] cmpl_tag,
    input  logic             ex_vld,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             wen_e,
    output logic             stall_e,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             cmpl_err
);

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [NUM_ENT-1:0] ent_vld;
    logic [4:0]         ent_rd [NUM_ENT];

    logic alloc_fire;
    logic cmpl_hit;
    logic err_nxt;
    logic any_hazard;

    // ------------------------------------------------------------------
    // Hazard of the E-stage instruction against one pending destination.
    // x0 is hardwired to zero, so a zero source or destination never matches.
    // This also covers an allocation whose destination is x0.
    // ------------------------------------------------------------------
    function automatic logic rd_hazard(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rde,
        input logic       wen
    );
        logic raw1;
        logic raw2;
        logic waw;
        raw1 = (rs1 != 5'd0) && (rs1 == rd);
        raw2 = (rs2 != 5'd0) && (rs2 == rd);
        waw  = wen && (rde != 5'd0) && (rde == rd);
        return raw1 || raw2 || waw;
    endfunction

    // ------------------------------------------------------------------
    // Free-entry selection: the lowest-index invalid entry. An entry being
    // completed this cycle is still valid, so it is not offered until the
    // next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        logic found;
        alloc_tag = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (!ent_vld[i] && !found) begin
                alloc_tag = TAG_W'(i);
                found     = 1'b1;
            end
        end
    end

    assign alloc_rdy  = ~(&ent_vld);
    assign alloc_fire = alloc_vld & alloc_rdy;
    assign cmpl_hit   = cmpl_vld & ent_vld[cmpl_tag];
    assign err_nxt    = (alloc_vld & ~alloc_rdy) | (cmpl_vld & ~ent_vld[cmpl_tag]);

    // ------------------------------------------------------------------
    // Stall generation.
    // A completing entry still counts in its completion cycle: the result is
    // only in the RF from the next cycle, and there is no W forwarding.
    // The allocation in flight this cycle is checked too. Its M-stage result
    // does not exist yet, so the M bypass leg must not be used for it.
    // ------------------------------------------------------------------
    always_comb begin
        any_hazard = 1'b0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (ent_vld[i] && rd_hazard(ent_rd[i], rs1_e, rs2_e, rd_e, wen_e)) begin
                any_hazard = 1'b1;
            end
        end
        if (alloc_fire && rd_hazard(alloc_rd, rs1_e, rs2_e, rd_e, wen_e)) begin
            any_hazard = 1'b1;
        end
    end

    assign stall_e = ex_vld & any_hazard;

    // ------------------------------------------------------------------
    // State update. A hit completion targets a valid entry, and an allocation
    // targets an invalid one. They never address the same entry in one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_vld  <= '0;
            for (int i = 0; i < NUM_ENT; i++) begin
                ent_rd[i] <= 5'd0;
            end
            pend_cnt <= '0;
            cmpl_err <= 1'b0;
        end else begin
            if (cmpl_hit) begin
                ent_vld[cmpl_tag] <= 1'b0;
            end
            if (alloc_fire) begin
                ent_vld[alloc_tag] <= 1'b1;
                ent_rd[alloc_tag]  <= alloc_rd;
            end
            case ({alloc_fire, cmpl_hit})
                2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
                2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
            cmpl_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_cpu7_exu_ecl_ldscb.sv
// ----------------------------------------------------------------------------
// tb_cpu7_exu_ecl_ldscb
//
// Directed bench for the long-latency scoreboard. A table of per-cycle
// records gives the inputs and the hand-computed outputs for each cycle. The
// bench drives inputs on the falling edge and samples 1 ns later. Registered
// outputs therefore show the effect of all earlier rising edges. The sequences
// for reset and reset asserted mid-stall are written out by hand.
// ----------------------------------------------------------------------------
module tb_cpu7_exu_ecl_ldscb;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       resetn;
    always #5 clk = ~clk;

    logic       alloc_vld;
    logic [4:0] alloc_rd;
    logic       alloc_rdy;
    logic [1:0] alloc_tag;
    logic       cmpl_vld;
    logic [1:0] cmpl_tag;
    logic       ex_vld;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic       wen_e;
    logic       stall_e;
    logic [2:0] pend_cnt;
    logic       cmpl_err;

    cpu7_exu_ecl_ldscb #(
        .NUM_ENT (4),
        .TAG_W   (2),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .alloc_vld (alloc_vld),
        .alloc_rd  (alloc_rd),
        .alloc_rdy (alloc_rdy),
        .alloc_tag (alloc_tag),
        .cmpl_vld  (cmpl_vld),
        .cmpl_tag  (cmpl_tag),
        .ex_vld    (ex_vld),
        .rs1_e     (rs1_e),
        .rs2_e     (rs2_e),
        .rd_e      (rd_e),
        .wen_e     (wen_e),
        .stall_e   (stall_e),
        .pend_cnt  (pend_cnt),
        .cmpl_err  (cmpl_err)
    );

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       av;
        logic [4:0] ard;
        logic       cv;
        logic [1:0] ctag;
        logic       ev;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rde;
        logic       wen;
        logic       rdy;
        logic [1:0] tag;
        logic       stall;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic add(
        input logic       av,  input logic [4:0] ard,
        input logic       cv,  input logic [1:0] ctag,
        input logic       ev,  input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rde, input logic       wen,
        input logic       rdy, input logic [1:0] tag, input logic stall,
        input logic [2:0] cnt, input logic       err
    );
        vec_t v;
        v.av = av;   v.ard = ard; v.cv = cv;   v.ctag = ctag;
        v.ev = ev;   v.rs1 = rs1; v.rs2 = rs2; v.rde = rde; v.wen = wen;
        v.rdy = rdy; v.tag = tag; v.stall = stall; v.cnt = cnt; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        alloc_vld = 1'b0; alloc_rd = 5'd0;
        cmpl_vld  = 1'b0; cmpl_tag = 2'd0;
        ex_vld    = 1'b0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0; wen_e = 1'b0;
    endtask

    task automatic check_all(input int idx, input logic rdy, input logic [1:0] tag,
                             input logic stall, input logic [2:0] cnt, input logic err);
        chk("alloc_rdy", idx, {7'd0, alloc_rdy}, {7'd0, rdy});
        chk("alloc_tag", idx, {6'd0, alloc_tag}, {6'd0, tag});
        chk("stall_e",   idx, {7'd0, stall_e},   {7'd0, stall});
        chk("pend_cnt",  idx, {5'd0, pend_cnt},  {5'd0, cnt});
        chk("cmpl_err",  idx, {7'd0, cmpl_err},  {7'd0, err});
    endtask

    // Watchdog: the run is short, so this only fires on a broken bench.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //  av ard cv ct  ev rs1 rs2 rde wen | rdy tag stall cnt err
        // Alloc rd5 with RAW in the same cycle; completion and stall release.
        add(1, 5, 0, 0,  1, 5, 0, 0, 0,   1, 0, 1, 0, 0);
        add(0, 0, 0, 0,  1, 5, 0, 0, 0,   1, 1, 1, 1, 0);
        add(0, 0, 1, 0,  1, 5, 0, 0, 0,   1, 1, 1, 1, 0);
        add(0, 0, 0, 0,  1, 5, 0, 0, 0,   1, 0, 0, 0, 0);
        // Fill rd1..rd4; overflow alloc (also checks no stall from it).
        add(1, 1, 0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 2, 0, 0,  0, 0, 0, 0, 0,   1, 1, 0, 1, 0);
        add(1, 3, 0, 0,  0, 0, 0, 0, 0,   1, 2, 0, 2, 0);
        add(1, 4, 0, 0,  0, 0, 0, 0, 0,   1, 3, 0, 3, 0);
        add(1, 6, 0, 0,  1, 6, 0, 0, 0,   0, 0, 0, 4, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 4, 1);
        add(0, 0, 1, 2,  0, 0, 0, 0, 0,   0, 0, 0, 4, 0);
        add(0, 0, 0, 0,  1, 3, 0, 0, 0,   1, 2, 0, 3, 0);
        // Refill entry2, free entry3, then alloc+cmpl in one cycle.
        add(1, 3, 0, 0,  0, 0, 0, 0, 0,   1, 2, 0, 3, 0);
        add(0, 0, 1, 3,  0, 0, 0, 0, 0,   0, 0, 0, 4, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0, 0,   1, 3, 0, 3, 0);
        add(1, 8, 1, 1,  1, 8, 0, 0, 0,   1, 3, 1, 3, 0);
        add(0, 0, 0, 0,  1, 2, 0, 0, 0,   1, 1, 0, 3, 0);
        add(0, 0, 0, 0,  1, 0, 8, 0, 0,   1, 1, 1, 3, 0);
        // Drain.
        add(0, 0, 1, 0,  0, 0, 0, 0, 0,   1, 1, 0, 3, 0);
        add(0, 0, 1, 2,  0, 0, 0, 0, 0,   1, 0, 0, 2, 0);
        add(0, 0, 1, 3,  0, 0, 0, 0, 0,   1, 0, 0, 1, 0);
        // rd7, rd9 pending; RAW on rs2; x0 entries/sources; ex_vld low.
        add(1, 7, 0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 9, 0, 0,  0, 0, 0, 0, 0,   1, 1, 0, 1, 0);
        add(0, 0, 0, 0,  1, 3, 9, 0, 0,   1, 2, 1, 2, 0);
        add(1, 0, 0, 0,  1, 0, 0, 0, 0,   1, 2, 0, 2, 0);
        add(0, 0, 0, 0,  0, 7, 9, 0, 0,   1, 3, 0, 3, 0);
        add(0, 0, 0, 0,  1, 7, 0, 0, 0,   1, 3, 1, 3, 0);
        add(0, 0, 0, 0,  1, 1, 2, 0, 1,   1, 3, 0, 3, 0);
        // WAW against rd12: in flight, then pending, then wen_e low.
        add(1, 12, 1, 0, 1, 1, 2, 12, 1,  1, 3, 1, 3, 0);
        add(0, 0, 0, 0,  1, 1, 2, 12, 1,  1, 0, 1, 3, 0);
        add(0, 0, 0, 0,  1, 1, 2, 12, 0,  1, 0, 0, 3, 0);
        // Completion to an invalid entry.
        add(0, 0, 1, 0,  0, 0, 0, 0, 0,   1, 0, 0, 3, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 3, 1);
        add(0, 0, 0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 3, 0);

        // Reset state, with an E instruction present.
        drive_idle();
        resetn = 1'b0;
        ex_vld = 1'b1; rs1_e = 5'd5;
        #12;
        check_all(-1, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven section.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            alloc_vld = vecs[i].av;  alloc_rd = vecs[i].ard;
            cmpl_vld  = vecs[i].cv;  cmpl_tag = vecs[i].ctag;
            ex_vld    = vecs[i].ev;  rs1_e = vecs[i].rs1; rs2_e = vecs[i].rs2;
            rd_e      = vecs[i].rde; wen_e = vecs[i].wen;
            #1;
            check_all(i, vecs[i].rdy, vecs[i].tag, vecs[i].stall,
                      vecs[i].cnt, vecs[i].err);
        end

        // Reset asserted mid-stall: entries rd9, rd0 and rd12 are pending.
        @(negedge clk);
        drive_idle();
        ex_vld = 1'b1; rs1_e = 5'd12;
        #1;
        check_all(100, 1'b1, 2'd0, 1'b1, 3'd3, 1'b0);
        #1;
        resetn = 1'b0;
        #1;
        check_all(101, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check_all(102, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu7_exu_ecl_ldscb.md
Name: cpu7_exu_ecl_ldscb

Overview:
- Long-latency writeback scoreboard and stall controller for the EXU operand bypass network.
- Tracks in-flight load and divide destinations whose results are not yet available on the M/W bypass paths.
- Stalls the E-stage instruction on RAW or WAW hazards against those destinations.
- Releases the stall once the completing write has reached the register file, so the consumer then takes the RF leg of the rs mux.

Parameters:
NUM_ENT, 4, number of outstanding long-latency writes tracked (power of two, 2..8)
TAG_W, 2, tag width, log2(NUM_ENT)
CNT_W, 3, width of pend_cnt, log2(NUM_ENT)+1

Ports:
clk  in  1  core clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
alloc_vld  in  1  M stage issues a long-latency op that writes alloc_rd
alloc_rd  in  5  destination register of the allocating op
alloc_rdy  out  1  at least one free entry exists (combinational from state)
alloc_tag  out  TAG_W  index of the entry the allocation takes this cycle
cmpl_vld  in  1  long-latency result is written to RF this cycle (W stage)
cmpl_tag  in  TAG_W  entry being completed
ex_vld  in  1  valid instruction in E
rs1_e  in  5  E-stage source 1
rs2_e  in  5  E-stage source 2
rd_e  in  5  E-stage destination
wen_e  in  1  E-stage instruction writes rd_e
stall_e  out  1  hold E stage and upstream (combinational)
pend_cnt  out  CNT_W  number of valid entries (registered)
cmpl_err  out  1  one-cycle registered pulse on a protocol violation

Behaviour:
- State per entry: vld and rd[4:0].
- Reset (resetn low, asynchronous): all vld=0, rd=0, pend_cnt=0, cmpl_err=0.
  - Outputs after reset: alloc_rdy=1, alloc_tag=0, stall_e=0.
- Allocation:
  - alloc_tag = lowest-index entry with vld=0. alloc_rdy = OR of ~vld.
  - On alloc_vld & alloc_rdy: entry[alloc_tag] gets vld=1, rd=alloc_rd at the next edge.
  - alloc_vld while alloc_rdy=0: ignored, and cmpl_err pulses the next cycle. The issuer must gate on alloc_rdy.
  - alloc_rd=0 allocates normally but never causes a hazard.
- Completion:
  - On cmpl_vld with entry[cmpl_tag].vld=1: vld clears at the next edge.
  - cmpl_vld to an invalid entry: ignored, cmpl_err pulses the next cycle.
- Simultaneous alloc and cmpl:
  - Both take effect in the same cycle.
  - The completing entry is still valid in that cycle, so it is not selectable by alloc_tag. It becomes free the following cycle.
- Hazard detection (combinational). For each valid entry, and for the in-flight allocation when alloc_vld & alloc_rdy:
  - raw1 = rs1_e nonzero & rs1_e==rd
  - raw2 = rs2_e nonzero & rs2_e==rd
  - waw = wen_e & rd_e nonzero & rd_e==rd
- stall_e = ex_vld & OR over all of (raw1|raw2|waw).
- The same-cycle alloc check is mandatory: the M-stage allocating op has no bypassable result. Without it the M bypass leg would forward garbage.
- Stall release timing:
  - An entry completing in cycle N still stalls in cycle N.
  - stall_e drops in cycle N+1, when the RF holds the value.
  - No same-cycle W forwarding of long-latency results.
- pend_cnt equals the number of entries with vld=1. It updates at the same edge as vld:
  - +1 on alloc only
  - -1 on valid cmpl only
  - unchanged when both occur
- stall_e does not block alloc or cmpl; the M and W stages keep advancing under an E stall.
- Full condition:
  - With NUM_ENT valid entries, alloc_rdy=0.
  - A cmpl in cycle N makes alloc_rdy=1 in N+1.
- Reset asserted mid-operation discards all entries. The pipeline is flushed by the same reset.

Test Plan:
- Reset, then alloc_vld with alloc_rd=5 → alloc_tag=0 and, same cycle, stall_e=1 for ex_vld rs1_e=5. Next cycle pend_cnt=1. Cmpl tag0 in cycle N → stall_e=1 in N, 0 in N+1, pend_cnt=0.
- Fill 4 entries (rd=1,2,3,4) → alloc_rdy=0, pend_cnt=4. alloc_vld again → no state change, cmpl_err=1 for one cycle. Cmpl tag2 → next cycle alloc_rdy=1, alloc_tag=2.
- Entries rd=7 and rd=9. E has rs1=3, rs2=9 → stall_e=1. rs1=0, rs2=0 with rd=0 allocated → stall_e=0. ex_vld=0 → stall_e=0.
- WAW: entry rd=12 pending. E has wen_e=1, rd_e=12, sources 1/2 → stall_e=1. Same with wen_e=0 → stall_e=0.
- Same-cycle alloc (rd=8) and cmpl (tag1) with 4 entries minus one free (tag3) → alloc_tag=3. Next cycle pend_cnt unchanged and entry1 free.
- cmpl_vld on a never-allocated tag → cmpl_err pulse, pend_cnt unchanged. Assert resetn low mid-stall → stall_e=0 and pend_cnt=0 immediately.
